riscv_rf_core: RTL

Integer register file that sits on the responder side of riscv_rf_if (rf modport). It serves two combinational read ports and one synchronous write port.
Storage has no reset so it can infer as memory. Instead, a sweep state machine zeroes every entry after reset or on request, and holds off consumers with rdy until the sweep finishes.
Includes hardwired-zero x0 and an optional write-to-read bypass.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/riscv_rf_clr_ctrl.sv | 72 +++++++
 rtl/riscv_rf_core.sv | 83 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V integer datapath types and register-file constants.
package riscv_pkg;

    localparam int unsigned RISCV_XLEN          = 32;
    localparam int unsigned RISCV_RF_ADDR_WIDTH = 5;
    localparam int unsigned RISCV_RF_DEPTH      = 2 ** RISCV_RF_ADDR_WIDTH;

    typedef logic [RISCV_XLEN-1:0]          riscv_data_t;
    typedef logic [RISCV_RF_ADDR_WIDTH-1:0] riscv_rf_addr_t;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } riscv_rf_state_e;

endpackage

// File: rtl/riscv_rf_clr_ctrl.sv
// Zeroing-sweep controller: walks every register-file entry after reset or
// on request, and reports rdy once the whole array has been cleared.
module riscv_rf_clr_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RISCV_RF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  sweep_we,
    output logic [ADDR_WIDTH-1:0] sweep_addr,
    output logic                  rdy
);

    // One spare bit on the pointer keeps the final increment from wrapping.
    localparam int unsigned         PTR_W    = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(DEPTH - 1);

    riscv_rf_state_e  state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             rdy_q, rdy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rdy_d   = rdy_q;
        case (state_q)
            RF_CLEAR: begin
                if (clr_req) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST_PTR) begin
                    ptr_d   = ptr_q + PTR_W'(1);
                    state_d = RF_READY;
                    rdy_d   = 1'b1;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            RF_READY: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    ptr_d   = '0;
                    rdy_d   = 1'b0;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                ptr_d   = '0;
                rdy_d   = 1'b0;
            end
        endcase
    end

    assign sweep_we   = (state_q == RF_CLEAR);
    assign sweep_addr = ptr_q[ADDR_WIDTH-1:0];
    assign rdy        = rdy_q;

endmodule

// File: rtl/riscv_rf_core.sv
// Integer register file: two combinational read ports, one synchronous write
// port, hardwired-zero x0, optional write-to-read bypass, swept clear.
module riscv_rf_core
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = RISCV_RF_ADDR_WIDTH,
    parameter int unsigned DEPTH       = 2 ** ADDR_WIDTH,
    parameter bit          BYPASS_EN   = 1'b1,
    parameter bit          ZERO_REG_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr_A,
    input  logic [ADDR_WIDTH-1:0] rd_addr_B,
    output logic [DATA_WIDTH-1:0] data_out_A,
    output logic [DATA_WIDTH-1:0] data_out_B,
    output logic                  rdy
);

    logic                  sweep_we;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  user_we;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    riscv_rf_clr_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_clr_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (clr_req),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .rdy        (rdy)
    );

    // A clear request wins over a coincident user write; x0 writes vanish.
    assign user_we = wr_en && rdy && !clr_req &&
                     !(ZERO_REG_EN && (wr_addr == '0));

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = wr_addr;
        mem_data = data_in;
        if (sweep_we) begin
            mem_we   = 1'b1;
            mem_addr = sweep_addr;
            mem_data = '0;
        end else if (user_we) begin
            mem_we = 1'b1;
        end
    end

    // No reset on storage so the array can map onto a memory macro.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    // Later assignments override earlier ones, giving gate > x0 > bypass > array.
    always_comb begin
        data_out_A = mem[rd_addr_A];
        if (BYPASS_EN && wr_en && (wr_addr == rd_addr_A)) data_out_A = data_in;
        if (ZERO_REG_EN && (rd_addr_A == '0))             data_out_A = '0;
        if (!rdy)                                          data_out_A = '0;

        data_out_B = mem[rd_addr_B];
        if (BYPASS_EN && wr_en && (wr_addr == rd_addr_B)) data_out_B = data_in;
        if (ZERO_REG_EN && (rd_addr_B == '0))             data_out_B = '0;
        if (!rdy)                                          data_out_B = '0;
    end

endmodule
